// File: rtl/cpu_clk_monitor_if.sv
// Signal bundle between the divided-CPU-clock monitor and its consumers on the board clock.
interface cpu_clk_monitor_if;
  logic        Clk_CPU;
  logic        clr;
  logic        rise;
  logic        fall;
  logic [31:0] cyc_cnt;
  logic [31:0] period;
  logic        period_valid;
  logic        stalled;

  modport master (
    output Clk_CPU, clr,
    input  rise, fall, cyc_cnt, period, period_valid, stalled
  );

  modport slave (
    input  Clk_CPU, clr,
    output rise, fall, cyc_cnt, period, period_valid, stalled
  );
endinterface

// File: rtl/cpu_clk_monitor.sv
// Samples the divided CPU clock on clk: edge strobes, rise count, period and stall detection.
// Period capture is built only when CPU_CLK_PERIOD_MEAS_EN is defined.
module cpu_clk_monitor #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd134217728
) (
  input  logic             clk,
  input  logic             rst,
  cpu_clk_monitor_if.slave bus
);

  localparam int            WIN     = SYNC_STAGES + 1;
  localparam int            WW      = $clog2(WIN + 1);
  localparam logic [WW-1:0] WIN_END = WW'(WIN);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   d_r;
  logic [WW-1:0]          win_cnt_r;
  logic                   rise_r;
  logic                   fall_r;
  logic [31:0]            cyc_r;
  logic [31:0]            gap_r;
  logic                   s_s;
  logic                   open_s;
  logic                   rise_ev_s;
  logic                   fall_ev_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain, previous-sample flop and post-reset arming window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r    <= '0;
      d_r       <= 1'b0;
      win_cnt_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.Clk_CPU};
      d_r    <= s_s;
      if (!open_s) begin
        win_cnt_r <= win_cnt_r + WW'(1);
      end
    end
  end

  // Edge events, suppressed until the chain holds real samples
  always_comb begin
    open_s    = (win_cnt_r == WIN_END);
    rise_ev_s = open_s & s_s & ~d_r;
    fall_ev_s = open_s & ~s_s & d_r;
  end

  // Strobes, rise counter and rise-to-rise gap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      cyc_r  <= 32'd0;
      gap_r  <= 32'd0;
    end else begin
      rise_r <= rise_ev_s;
      fall_r <= fall_ev_s;
      if (bus.clr) begin
        cyc_r <= 32'd0;
      end else if (rise_ev_s) begin
        cyc_r <= cyc_r + 32'd1;
      end
      // gap keeps timing edges even when clr swallows the count
      if (rise_ev_s) begin
        gap_r <= 32'd0;
      end else begin
        gap_r <= sat_inc(gap_r);
      end
    end
  end

  assign bus.rise    = rise_r;
  assign bus.fall    = fall_r;
  assign bus.cyc_cnt = cyc_r;
  assign bus.stalled = (gap_r >= TIMEOUT);

`ifdef CPU_CLK_PERIOD_MEAS_EN
  logic        armed_r;
  logic [31:0] period_r;
  logic        valid_r;

  // First rise after reset/clr arms; each later rise captures gap+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_r  <= 1'b0;
      period_r <= 32'd0;
      valid_r  <= 1'b0;
    end else if (bus.clr) begin
      armed_r <= 1'b0;
      valid_r <= 1'b0;
    end else if (rise_ev_s) begin
      if (armed_r) begin
        period_r <= sat_inc(gap_r);
        valid_r  <= 1'b1;
      end else begin
        armed_r <= 1'b1;
      end
    end
  end

  assign bus.period       = period_r;
  assign bus.period_valid = valid_r;
`else
  assign bus.period       = 32'd0;
  assign bus.period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clk_monitor.sv
// Directed and randomized bench for cpu_clk_monitor against an edge-index reference model.
module tb_cpu_clk_monitor;
  localparam int          SYNC = 2;
  localparam logic [31:0] TMO  = 32'd64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_clk_monitor_if bus ();

  cpu_clk_monitor #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: clk edges counted from reset release, sampled levels per edge
  int          n;
  bit          samp[$];
  int          last_rise;
  int unsigned m_cyc;
  int unsigned m_period;
  bit          m_armed;
  bit          m_valid;
  bit          e_rise;
  bit          e_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sv(input int i);
    if (i >= 1 && i <= samp.size()) return samp[i-1];
    return 1'b0;
  endfunction

  function automatic bit will_rise();
    int k = n + 1;
    return (k > SYNC + 1) && sv(k - SYNC) && !sv(k - SYNC - 1);
  endfunction

  task automatic model_reset();
    n = 0;
    samp.delete();
    last_rise = 0;
    m_cyc = 0;
    m_period = 0;
    m_armed = 1'b0;
    m_valid = 1'b0;
    e_rise = 1'b0;
    e_fall = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rise"},    bus.rise,         32'd0);
    chk({tag, "_fall"},    bus.fall,         32'd0);
    chk({tag, "_cyc"},     bus.cyc_cnt,      32'd0);
    chk({tag, "_period"},  bus.period,       32'd0);
    chk({tag, "_valid"},   bus.period_valid, 32'd0);
    chk({tag, "_stalled"}, bus.stalled,      32'd0);
  endtask

  task automatic step(input bit v, input bit c);
    bus.Clk_CPU = v;
    bus.clr     = c;
    @(posedge clk);
    n++;
    samp.push_back(v);
    e_rise = (n > SYNC + 1) && sv(n - SYNC) && !sv(n - SYNC - 1);
    e_fall = (n > SYNC + 1) && !sv(n - SYNC) && sv(n - SYNC - 1);
    if (c) begin
      m_cyc   = 0;
      m_armed = 1'b0;
      m_valid = 1'b0;
    end else if (e_rise) begin
      m_cyc++;
      if (m_armed) begin
        m_period = n - last_rise;
        m_valid  = 1'b1;
      end else begin
        m_armed = 1'b1;
      end
    end
    if (e_rise) last_rise = n;
    #1;
    chk("rise",    bus.rise,    32'(e_rise));
    chk("fall",    bus.fall,    32'(e_fall));
    chk("cyc_cnt", bus.cyc_cnt, m_cyc);
    chk("stalled", bus.stalled, 32'((n - last_rise) >= int'(TMO)));
`ifdef CPU_CLK_PERIOD_MEAS_EN
    chk("period",  bus.period,       m_period);
    chk("valid",   bus.period_valid, 32'(m_valid));
`else
    chk("period",  bus.period,       32'd0);
    chk("valid",   bus.period_valid, 32'd0);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset(input bit lvl);
    rst = 1'b1;
    bus.Clk_CPU = lvl;
    bus.clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Square wave starting with the high phase; optional clr on the rise after clr_at counts
  task automatic clock_run(input int hi, input int lo, input int cycles, input int clr_at);
    int ph = 0;
    bit done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      bit v = (ph < hi);
      bit c = 1'b0;
      ph = (ph + 1) % (hi + lo);
      if (clr_at >= 0 && !done && will_rise() && m_cyc == clr_at) begin
        c = 1'b1;
        done = 1'b1;
      end
      step(v, c);
    end
  endtask

  initial begin
    bus.Clk_CPU = 1'b0;
    bus.clr = 1'b0;
    model_reset();

    // Steady 4/4 clock, first high sample at edge 10
    do_reset(1'b0);
    repeat (9) step(1'b0, 1'b0);
    clock_run(4, 4, 60, -1);
    chk("steady_cyc_ge5", 32'(bus.cyc_cnt >= 32'd5), 32'd1);

    // High through reset release: no edge, then one fall, then one rise
    do_reset(1'b1);
    repeat (8) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0);
    chk("high_rel_cyc", bus.cyc_cnt, 32'd1);

    // clr colliding with the fourth rise
    do_reset(1'b0);
    clock_run(4, 4, 80, 3);

    // Stall and recovery
    do_reset(1'b0);
    clock_run(4, 4, 24, -1);
    repeat (90) step(1'b0, 1'b0);
    chk("stall_hold", bus.stalled, 32'd1);
    clock_run(4, 4, 30, -1);

    // Randomized widths and sporadic clr
    do_reset(1'($urandom_range(0, 1)));
    for (int i = 0; i < 60; i++) begin
      int hi = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 80) : $urandom_range(2, 12);
      int lo = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 80) : $urandom_range(2, 12);
      repeat (hi) step(1'b1, 1'($urandom_range(0, 49) == 0));
      repeat (lo) step(1'b0, 1'($urandom_range(0, 49) == 0));
    end

    // Reset one cycle after a rise, then arming window with input already high
    do_reset(1'b0);
    clock_run(4, 4, 20, -1);
    for (int i = 0; i < 20 && !e_rise; i++) step(n % 8 < 4, 1'b0);
    chk("mid_rise_seen", 32'(e_rise), 32'd1);
    step(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) step(1'b1, 1'b0);
    clock_run(4, 4, 40, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_clk_monitor.md
# cpu_clk_monitor

Fast-domain monitor for the divided CPU clock. It samples `Clk_CPU` on the 100 MHz board clock and produces one-cycle rise and fall strobes, a CPU cycle count, a measured CPU clock period and a stall flag. It sits on the board top beside the clock divider, and it feeds display, debug and seven-segment logic that runs on `clk` and must not run on `Clk_CPU`.

## Interface
- `SYNC_STAGES`, default 2 — synchronizer depth; legal values ≥ 2.
- `TIMEOUT`, default 2^27 — number of `clk` cycles without a rising edge before `stalled` asserts; legal values 1 to 2^32−1.

- `clk` in 1 — system clock, 100 MHz.
- `rst` in 1 — reset; asynchronous, active-high.
- `Clk_CPU` in 1 — divided CPU clock; treated as asynchronous.
- `clr` in 1 — synchronous clear of `cyc_cnt` and of the period logic.
- `rise` out 1 — one-`clk` pulse per synchronized rising edge of `Clk_CPU`.
- `fall` out 1 — one-`clk` pulse per synchronized falling edge of `Clk_CPU`.
- `cyc_cnt` out 32 — count of rising edges.
- `period` out 32 — last measured rise-to-rise interval, in `clk` cycles.
- `period_valid` out 1 — `period` holds a real measurement.
- `stalled` out 1 — no rising edge seen for at least `TIMEOUT` cycles.

## Operation
- **Synchronizer:** `Clk_CPU` passes through a `SYNC_STAGES` flop chain; the last stage is `s`. A delay flop `d` holds the previous value of `s`.
- **Edge strobes:**
  - Registered: `rise <= s & ~d` and `fall <= ~s & d`.
  - Each strobe lasts exactly one `clk` cycle.
  - `rise` and `fall` are never high together.
- **Arming window:**
  - For the first `SYNC_STAGES + 1` cycles after `rst` deasserts, `d` tracks `s` and both strobes are forced to 0.
  - A `Clk_CPU` that is already high at reset release therefore produces no edge.
- **Cycle counter:**
  - `cyc_cnt` increments by 1 on each internal rise event, i.e. in the same cycle that `rise` is loaded.
  - It wraps from 0xFFFFFFFF to 0.
- **`clr`:** forces `cyc_cnt` to 0 and clears `period_valid` and `armed`. If `clr` and a rise event occur in the same cycle, `clr` wins: the edge is not counted and not used as the arming edge.
- **Gap counter:**
  - `gap` (32 bits) loads 0 on a rise event; otherwise it increments and saturates at 0xFFFFFFFF.
  - `stalled = (gap >= TIMEOUT)` is combinational from registers.
  - `stalled` stays high during the rise-event cycle and drops the cycle after.
- **Period capture:**
  - The first rise event after reset or `clr` only sets `armed`.
  - Each later rise event loads `period <= gap + 1`, saturating at 0xFFFFFFFF, and sets `period_valid`.
- **Reset:** all outputs and internal flops go to 0 (`rise`, `fall`, `cyc_cnt`, `period`, `period_valid`, `stalled`, synchronizer, `d`, `gap`, `armed`). Asserting `rst` mid-operation aborts any in-flight edge immediately.

## Timing
- **Latency:** if a `Clk_CPU` transition is first sampled at `clk` edge k, `s` changes after edge k+SYNC_STAGES−1 and the strobe is high in the cycle after edge k+SYNC_STAGES.
- **Update alignment:** `cyc_cnt`, `period` and `period_valid` update on the same edge that raises `rise`.
- **Guaranteed detection:** `Clk_CPU` high time and low time are each ≥ 2 `clk` cycles. The fastest divider setting gives 4 cycles high and 4 low, a period of 8.
- **Period resolution:** for a steady `Clk_CPU` of period P cycles, `period` = P ±1 (synchronizer uncertainty); in simulation with aligned edges it is exactly P.
- **Stall timing:** rise event at cycle t gives `gap` = k after edge t+k, so `stalled` is first high at cycle t+TIMEOUT.

## Configuration
- `CPU_CLK_PERIOD_MEAS_EN`
  - **Defined:** the period capture logic (`armed`, `period`, `period_valid`) is built.
  - **Undefined:** that capture logic is removed; `period` is tied to 0 and `period_valid` to 0. `gap`, `stalled`, `cyc_cnt` and the strobes are unchanged.

## Test plan
All scenarios use `SYNC_STAGES`=2, `TIMEOUT`=64 and the macro defined unless stated.
1. **Steady clock:** `Clk_CPU` with 4 cycles high / 4 low, first sampled high at edge 10 after reset release → `rise` high only in cycle 12→13. After the second rise: `period`=8, `period_valid`=1. After 5 rises: `cyc_cnt`=5.
2. **High at reset release:** `Clk_CPU` held high through and after reset release → no `rise` and no `fall`. The first subsequent low produces exactly one `fall`; the next high produces one `rise` and `cyc_cnt`=1.
3. **`clr` collides with rise:** `clr` pulsed in a rise-event cycle after 3 counted rises → `cyc_cnt`=0 and `period_valid`=0. The next rise only arms; the one after sets `period_valid`=1.
4. **Stall and recovery:** `Clk_CPU` stopped low after a rise at cycle t → `stalled`=0 at t+63 and 1 at t+64. Restarting the clock → `stalled` drops the cycle after the next rise event.
5. **Macro undefined:** rerun scenario 1 → `period`=0 and `period_valid`=0 throughout, with `cyc_cnt`, `rise` and `fall` identical to scenario 1.
6. **Reset mid-operation:** `rst` asserted one cycle after `rise` in a running clock → every output is 0 asynchronously. After release, no strobe appears during the 3-cycle arming window.
